// File: rtl/cpu_pipe_ctrl_if.sv
// Pipeline control bundle: hazard/redirect/memory status in, per-stage enable
// and flush levels plus the sequencer state out.
interface cpu_pipe_ctrl_if;
  logic       hd_stall;
  logic       branch_taken;
  logic       mem_busy;
  logic       fetch_en;
  logic       decode_en;
  logic       execute_en;
  logic       commit_en;
  logic       decode_flush;
  logic       execute_flush;
  logic [1:0] ctrl_state;

  modport master (
    input  hd_stall, branch_taken, mem_busy,
    output fetch_en, decode_en, execute_en, commit_en,
    output decode_flush, execute_flush, ctrl_state
  );

  modport slave (
    output hd_stall, branch_taken, mem_busy,
    input  fetch_en, decode_en, execute_en, commit_en,
    input  decode_flush, execute_flush, ctrl_state
  );
endinterface

// File: rtl/cpu_pipe_ctrl.sv
// Four-stage pipeline sequencer: turns stall, redirect and memory-busy into stage
// enables/flushes. Optional performance counters are enabled by CPU_PIPE_PERF_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal flow; stall bubbles, redirects and memory freezes decided here
//   FLUSH    | branch penalty: decode is loaded with NOPs until the counter expires
//   MEM_WAIT | commit memory access pending; whole pipe frozen
//   (3)      | illegal; reset-style outputs, returns to RUN next edge
module cpu_pipe_ctrl #(
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CPU_PIPE_PERF_EN
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  perf_stall_cyc,
  output logic [CNT_W-1:0]  perf_flush_cyc,
  output logic [CNT_W-1:0]  perf_mem_cyc,
`endif
  cpu_pipe_ctrl_if.master   pipe
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  localparam logic [3:0] PENALTY_RELOAD = 4'(BRANCH_PENALTY - 1);

  generate
    if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 15) begin : g_bad_penalty
      $error("BRANCH_PENALTY out of range 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
    end
  endgenerate

  state_t     state;
  logic [3:0] flush_cnt;

  logic       fetch_en;
  logic       decode_en;
  logic       execute_en;
  logic       commit_en;
  logic       decode_flush;
  logic       execute_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      flush_cnt <= 4'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (pipe.mem_busy) begin
            state <= ST_MEM_WAIT;
          end else if (pipe.branch_taken && (BRANCH_PENALTY > 1)) begin
            flush_cnt <= PENALTY_RELOAD;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // a memory freeze holds the remaining penalty cycles
          if (!pipe.mem_busy) begin
            flush_cnt <= flush_cnt - 4'd1;
            if (flush_cnt <= 4'd1) begin
              flush_cnt <= 4'd0;
              state     <= ST_RUN;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!pipe.mem_busy) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state     <= ST_RUN;
          flush_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    fetch_en      = 1'b0;
    decode_en     = 1'b0;
    execute_en    = 1'b0;
    commit_en     = 1'b0;
    decode_flush  = 1'b1;
    execute_flush = 1'b1;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (pipe.mem_busy) begin
            decode_flush  = 1'b0;
            execute_flush = 1'b0;
          end else if (pipe.branch_taken) begin
            fetch_en      = 1'b1;
            decode_en     = 1'b1;
            execute_en    = 1'b1;
            commit_en     = 1'b1;
          end else if (pipe.hd_stall) begin
            execute_en    = 1'b1;
            commit_en     = 1'b1;
            decode_flush  = 1'b0;
          end else begin
            fetch_en      = 1'b1;
            decode_en     = 1'b1;
            execute_en    = 1'b1;
            commit_en     = 1'b1;
            decode_flush  = 1'b0;
            execute_flush = 1'b0;
          end
        end
        ST_FLUSH: begin
          execute_flush = 1'b0;
          if (pipe.mem_busy) begin
            decode_flush = 1'b0;
          end else begin
            fetch_en   = 1'b1;
            decode_en  = 1'b1;
            execute_en = 1'b1;
            commit_en  = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          decode_flush  = 1'b0;
          execute_flush = 1'b0;
        end
        default: begin
          // illegal encoding keeps the reset-style output values
        end
      endcase
    end
  end

  assign pipe.fetch_en      = fetch_en;
  assign pipe.decode_en     = decode_en;
  assign pipe.execute_en    = execute_en;
  assign pipe.commit_en     = commit_en;
  assign pipe.decode_flush  = decode_flush;
  assign pipe.execute_flush = execute_flush;
  assign pipe.ctrl_state    = state;

`ifdef CPU_PIPE_PERF_EN
  logic stall_evt;
  logic mem_evt;

  assign stall_evt = (state == ST_RUN) && pipe.hd_stall && !pipe.mem_busy && !pipe.branch_taken;
  assign mem_evt   = (state == ST_MEM_WAIT) ||
                     (((state == ST_RUN) || (state == ST_FLUSH)) && pipe.mem_busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cyc <= '0;
      perf_mem_cyc   <= '0;
    end else if (perf_clr) begin
      perf_stall_cyc <= '0;
      perf_flush_cyc <= '0;
      perf_mem_cyc   <= '0;
    end else begin
      if (stall_evt && (perf_stall_cyc != '1)) begin
        perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
      end
      if (decode_flush && (perf_flush_cyc != '1)) begin
        perf_flush_cyc <= perf_flush_cyc + CNT_W'(1);
      end
      if (mem_evt && (perf_mem_cyc != '1)) begin
        perf_mem_cyc <= perf_mem_cyc + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Scoreboard bench for cpu_pipe_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_cpu_pipe_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [7:0] exp_q[$];

  cpu_pipe_ctrl_if pipe ();

`ifdef CPU_PIPE_PERF_EN
  logic       perf_clr;
  logic [3:0] perf_stall_cyc;
  logic [3:0] perf_flush_cyc;
  logic [3:0] perf_mem_cyc;

  cpu_pipe_ctrl #(.BRANCH_PENALTY(2), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .perf_clr(perf_clr),
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cyc(perf_flush_cyc),
    .perf_mem_cyc(perf_mem_cyc),
    .pipe(pipe.master)
  );
`else
  cpu_pipe_ctrl #(.BRANCH_PENALTY(2), .CNT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .pipe(pipe.master)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected code: {fetch, decode, execute, commit, dflush, eflush, state[1:0]}
  localparam logic [7:0] E_RST   = 8'h0C;
  localparam logic [7:0] E_IDLE  = 8'hF0;
  localparam logic [7:0] E_STALL = 8'h34;
  localparam logic [7:0] E_BR    = 8'hFC;
  localparam logic [7:0] E_FRZ   = 8'h00;
  localparam logic [7:0] E_FL    = 8'hF9;
  localparam logic [7:0] E_FLFRZ = 8'h01;
  localparam logic [7:0] E_MW    = 8'h02;

  task automatic step(input logic r, input logic h, input logic b, input logic m,
                      input logic [7:0] exp);
    @(posedge clk);
    #1;
    reset             = r;
    pipe.hd_stall     = h;
    pipe.branch_taken = b;
    pipe.mem_busy     = m;
    exp_q.push_back(exp);
  endtask

  initial begin : monitor
    logic [7:0] act;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {pipe.fetch_en, pipe.decode_en, pipe.execute_en, pipe.commit_en,
               pipe.decode_flush, pipe.execute_flush, pipe.ctrl_state};
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL pipe_out @%0t: got %h expected %h", $time, act, exp);
        end
      end
    end
  end

`ifdef CPU_PIPE_PERF_EN
  task automatic check_perf(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
`endif

  initial begin : stimulus
    int wait_cyc;
    n_checks          = 0;
    n_fail            = 0;
    reset             = 1'b1;
    pipe.hd_stall     = 1'b0;
    pipe.branch_taken = 1'b0;
    pipe.mem_busy     = 1'b0;
`ifdef CPU_PIPE_PERF_EN
    perf_clr          = 1'b0;
`endif

    // reset held 3 cycles, then release
    repeat (3) step(1, 0, 0, 0, E_RST);
    step(0, 0, 0, 0, E_IDLE);

    // two-cycle hazard stall
    step(0, 1, 0, 0, E_STALL);
    step(0, 1, 0, 0, E_STALL);
    step(0, 0, 0, 0, E_IDLE);

    // single redirect, penalty 2
    step(0, 0, 1, 0, E_BR);
    step(0, 0, 0, 0, E_FL);
    step(0, 0, 0, 0, E_IDLE);

    // redirect under memory busy: freeze, exit cycle, then branch sequence
    step(0, 0, 1, 1, E_FRZ);
    step(0, 0, 1, 1, E_MW);
    step(0, 0, 1, 1, E_MW);
    step(0, 0, 1, 0, E_MW);
    step(0, 0, 1, 0, E_BR);
    step(0, 0, 0, 0, E_FL);
    step(0, 0, 0, 0, E_IDLE);

    // memory busy during the flush cycle holds the penalty
    step(0, 0, 1, 0, E_BR);
    step(0, 0, 0, 1, E_FLFRZ);
    step(0, 0, 0, 1, E_FLFRZ);
    step(0, 0, 0, 0, E_FL);
    step(0, 0, 0, 0, E_IDLE);

    // stall and redirect ignored in FLUSH
    step(0, 0, 1, 0, E_BR);
    step(0, 1, 1, 0, E_FL);
    step(0, 1, 0, 0, E_STALL);

    // priority in RUN and inputs ignored in MEM_WAIT
    step(0, 1, 1, 0, E_BR);
    step(0, 0, 0, 0, E_FL);
    step(0, 1, 1, 1, E_FRZ);
    step(0, 1, 1, 0, E_MW);
    step(0, 0, 0, 0, E_IDLE);

    // reset mid-FLUSH and mid-MEM_WAIT
    step(0, 0, 1, 0, E_BR);
    step(1, 0, 0, 0, E_RST);
    step(0, 0, 0, 0, E_IDLE);
    step(0, 0, 0, 1, E_FRZ);
    step(1, 0, 0, 1, E_RST);
    step(0, 0, 0, 0, E_IDLE);

`ifdef CPU_PIPE_PERF_EN
    step(1, 0, 0, 0, E_RST);
    repeat (5) step(0, 1, 0, 0, E_STALL);
    step(0, 1, 0, 0, E_STALL);
    perf_clr = 1'b1;
    @(negedge clk);
    check_perf("perf_stall_5", perf_stall_cyc, 4'd5);
    check_perf("perf_flush_0", perf_flush_cyc, 4'd0);
    check_perf("perf_mem_0", perf_mem_cyc, 4'd0);
    step(0, 1, 0, 0, E_STALL);
    perf_clr = 1'b0;
    @(negedge clk);
    check_perf("perf_stall_clr", perf_stall_cyc, 4'd0);
    repeat (20) step(0, 1, 0, 0, E_STALL);
    @(negedge clk);
    check_perf("perf_stall_sat", perf_stall_cyc, 4'd15);
`endif

    step(0, 0, 0, 0, E_IDLE);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
